// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, state and select
// encodings, and the opcode-to-class decoder.
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_TRAP    = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
      CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
   } op_class_t;

   typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_REG = 2'd2} pc_src_t;
   typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3} wb_sel_t;
   typedef enum logic [1:0] {CAUSE_NONE = 2'd0, CAUSE_ILLEGAL = 2'd1, CAUSE_BUS_TIMEOUT = 2'd2} trap_cause_t;

   function automatic op_class_t classify(input logic [6:0] op);
      case (op)
         OP_R:      return CLS_R;
         OP_I:      return CLS_I;
         OP_LOAD:   return CLS_LOAD;
         OP_STORE:  return CLS_STORE;
         OP_BRANCH: return CLS_BRANCH;
         OP_JAL:    return CLS_JAL;
         OP_JALR:   return CLS_JALR;
         OP_LUI:    return CLS_LUI;
         OP_AUIPC:  return CLS_AUIPC;
         default:   return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/handshake_timer.sv
// Counts stalled handshake cycles; timeout fires on the stalled cycle that
// would make the count reach TIMEOUT_CYCLES.
module handshake_timer
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic wait_en,
   output logic timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt_q <= '0;
      else if (clear)   cnt_q <= '0;
      else if (wait_en) cnt_q <= cnt_q + 1'b1;
   end

   assign timeout = wait_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 control sequencer with handshake timeout and sticky trap.
//   state   | meaning
//   FETCH   | imem_req until imem_ready, load IR
//   DECODE  | classify opcode, latch funct3
//   EXECUTE | ALU operand select, resolve branches
//   MEM     | dmem_req until dmem_ready
//   WB      | register write, PC update, retire
//   TRAP    | everything idle until reset
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       branch_taken,
   output logic       imem_req,
   input  logic       imem_ready,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_ready,
   output logic       ir_we,
   output logic       pc_we,
   output logic       rf_we,
   output logic [1:0] pc_src,
   output logic [1:0] wb_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic [2:0] br_funct3,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [2:0] state_o
);

   state_t      state_q, state_d;
   op_class_t   cls_q, cls_d, cls_dec;
   trap_cause_t cause_q, cause_d;
   logic [2:0]  f3_q, f3_d;
   logic        wait_en, timeout, clear;

   assign wait_en = rst_n && (((state_q == ST_FETCH) && !imem_ready) ||
                              ((state_q == ST_MEM) && !dmem_ready));
   assign clear   = (state_d != state_q);
   assign cls_dec = classify(opcode);

   handshake_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .wait_en (wait_en),
      .timeout (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         cls_q   <= CLS_R;
         cause_q <= CAUSE_NONE;
         f3_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cause_q <= cause_d;
         f3_q    <= f3_d;
      end
   end

   // Outputs are gated by rst_n so reset silences them in the same cycle.
   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      cause_d   = cause_q;
      f3_d      = f3_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      pc_src    = PC_PLUS4;
      wb_sel    = WB_ALU;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      retire    = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = ST_DECODE;
               end else if (timeout) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_BUS_TIMEOUT;
               end
            end
            ST_DECODE: begin
               cls_d = cls_dec;
               f3_d  = funct3;
               if (cls_dec == CLS_ILLEGAL) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end else begin
                  state_d = ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               case (cls_q)
                  CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR: alu_b_sel = 1'b1;
                  CLS_AUIPC: begin
                     alu_a_sel = 1'b1;
                     alu_b_sel = 1'b1;
                  end
                  default: ;
               endcase
               case (cls_q)
                  CLS_BRANCH: begin
                     pc_we   = 1'b1;
                     pc_src  = branch_taken ? PC_IMM : PC_PLUS4;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end
                  CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                  default:             state_d = ST_WB;
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (cls_q == CLS_STORE);
               if (dmem_ready) begin
                  if (cls_q == CLS_STORE) begin
                     pc_we   = 1'b1;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_WB;
                  end
               end else if (timeout) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_BUS_TIMEOUT;
               end
            end
            ST_WB: begin
               rf_we   = 1'b1;
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = ST_FETCH;
               case (cls_q)
                  CLS_LOAD:          wb_sel = WB_LOAD;
                  CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                  CLS_LUI:           wb_sel = WB_IMM;
                  default:           wb_sel = WB_ALU;
               endcase
               case (cls_q)
                  CLS_JAL:  pc_src = PC_IMM;
                  CLS_JALR: pc_src = PC_REG;
                  default:  pc_src = PC_PLUS4;
               endcase
            end
            default: state_d = ST_TRAP;
         endcase
      end
   end

   assign trap       = rst_n && (state_q == ST_TRAP);
   assign trap_cause = cause_q;
   assign br_funct3  = f3_q;
   assign state_o    = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, meaning the max wait cycles on imem/dmem handshake before bus-error trap.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  decoded opcode of the instruction register.
REQ-005 funct3  input  3  decoded funct3; used only for branch condition select passthrough.
REQ-006 branch_taken  input  1  comparator result for the current branch, valid in EXECUTE.
REQ-007 imem_req / imem_ready  output / input  1 / 1  instruction-fetch handshake.
REQ-008 dmem_req / dmem_we / dmem_ready  output / output / input  1 / 1 / 1  data-memory handshake.
REQ-009 ir_we, pc_we, rf_we  output  1 each  instruction-reg, PC, and register-file write enables.
REQ-010 pc_src  output  2  0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1.
REQ-011 wb_sel  output  2  0 ALU, 1 load data, 2 PC+4, 3 imm.
REQ-012 alu_a_sel / alu_b_sel  output  1 / 1  a: 0 rs1, 1 PC; b: 0 rs2, 1 imm.
REQ-013 br_funct3  output  3  funct3 registered in DECODE, held to comparator.
REQ-014 retire  output  1  one-cycle pulse when an instruction completes.
REQ-015 trap / trap_cause  output  1 / 2  sticky trap; cause 1 illegal opcode, 2 bus timeout.
REQ-016 state_o  output  3  current state encoding, debug only.

Function
REQ-017 States SHALL be FETCH, DECODE, EXECUTE, MEM, WB, TRAP; all outputs decoded from registered state (Moore), except ir_we/pc_we/retire which may depend on ready inputs.
REQ-018 FETCH: imem_req=1 held until imem_ready; in that same cycle ir_we=1, next DECODE.
REQ-019 DECODE: one cycle; register opcode class and funct3; opcodes 0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111 -> EXECUTE; any other -> TRAP, cause 1.
REQ-020 EXECUTE (one cycle): R -> alu_b_sel=0; I/load/store/JALR -> alu_b_sel=1; AUIPC -> alu_a_sel=1, alu_b_sel=1.
REQ-021 EXECUTE branch: pc_we=1, pc_src=1 if branch_taken else 0, retire=1, next FETCH.
REQ-022 EXECUTE load/store -> MEM; R/I/LUI/AUIPC/JAL/JALR -> WB.
REQ-023 MEM: dmem_req=1, dmem_we=1 for store only, held stable until dmem_ready; load -> WB; store -> pc_we=1, pc_src=0, retire=1, next FETCH.
REQ-024 WB: rf_we=1, pc_we=1, retire=1 for exactly one cycle, next FETCH; wb_sel 0 for R/I/AUIPC, 1 load, 2 JAL/JALR, 3 LUI; pc_src 1 JAL, 2 JALR, else 0.
REQ-025 rf_we SHALL never assert outside WB; pc_we at most once per instruction.
REQ-026 Wait counter SHALL count cycles with req high and ready low in FETCH/MEM, clear on state change; reaching TIMEOUT_CYCLES -> TRAP, cause 2, req dropped.
REQ-027 Ready asserted on the timeout cycle SHALL win (handshake completes, no trap).
REQ-028 TRAP: all enables and reqs 0, trap=1, held until reset.
REQ-029 Minimum latency with zero-wait memories: ALU op 4 cycles, branch 3, load 5, store 4 (FETCH counted).

Reset
REQ-030 rst_n low SHALL asynchronously force state FETCH, counter 0, trap=0, trap_cause=0, br_funct3=0, all enables/reqs/retire 0, selects 0.
REQ-031 Reset mid-MEM SHALL drop dmem_req immediately; first cycle after release issues imem_req.

Structure
REQ-032 Shared package ctrl_pkg SHALL hold opcode constants, state enum, pc_src, wb_sel and trap_cause enums.
REQ-033 Sub-module handshake_timer (counter + timeout flag, parameter TIMEOUT_CYCLES) SHALL be instantiated once.

Verification
REQ-034 add (0x00B50533), imem_ready immediate -> ir_we at cycle 1, rf_we wb_sel=0 at cycle 4, retire once.
REQ-035 beq taken, branch_taken=1 -> EXECUTE pc_we=1 pc_src=1, no rf_we, retire at cycle 3.
REQ-036 lw with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB wb_sel=1.
REQ-037 sw with dmem_ready never -> after 16 MEM cycles trap=1 cause=2, dmem_req=0 thereafter.
REQ-038 opcode 0x7F -> TRAP cause 1 after DECODE, no pc_we/rf_we ever.
REQ-039 rst_n asserted mid-MEM of lw -> outputs zero same cycle, state_o=FETCH, clean refetch after release.
